axi4_line_fetch: RTL and testbench

- AXI4 read-channel master; the initiator end of the memory slave on the `axi4_if` read channels.
- Accepts a line-refill request from the core/I-cache side.
- Issues one INCR burst of LINE_WORDS beats, collects the beats into a line buffer, and returns the whole line with an error flag.
- Sits between the fetch/cache logic and the `axi4_if.master` port toward the memory.

---
 rtl/axi4_if.sv | 57 +++++
 rtl/axi4_line_fetch.sv | 143 ++++++++++++++
 tb/tb_axi4_line_fetch.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_if.sv
// AXI4 bus bundle shared by the line-fetch master and its memory slave.
// Carries all five channels; this block only exercises AR and R, but the
// write channels are present so a full slave can hang off the same bundle.
//   master modport : drives AR/AW/W request fields and rready/bready
//   slave  modport : drives arready/awready/wready and the R/B responses
`timescale 1ns/1ps
interface axi4_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) ();
  // read address channel
  logic                    arvalid;
  logic                    arready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  // read data channel
  logic                    rvalid;
  logic                    rready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  // write address channel
  logic                    awvalid;
  logic                    awready;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  // write data channel
  logic                    wvalid;
  logic                    wready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  // write response channel
  logic                    bvalid;
  logic                    bready;
  logic [1:0]              bresp;

  modport master (
    output arvalid, araddr, arlen, arsize, arburst, rready,
    output awvalid, awaddr, awlen, awsize, awburst,
    output wvalid, wdata, wstrb, wlast, bready,
    input  arready, rvalid, rdata, rresp, rlast,
    input  awready, wready, bvalid, bresp
  );

  modport slave (
    input  arvalid, araddr, arlen, arsize, arburst, rready,
    input  awvalid, awaddr, awlen, awsize, awburst,
    input  wvalid, wdata, wstrb, wlast, bready,
    output arready, rvalid, rdata, rresp, rlast,
    output awready, wready, bvalid, bresp
  );
endinterface

// File: rtl/axi4_line_fetch.sv
// AXI4 read master that refills one cache line per request.
// A request address is rounded down to its line, one INCR burst of
// LINE_WORDS beats is issued, the beats are gathered into a line buffer and
// the whole line is handed back with a sticky error flag.
//   clk, reset             : clock, synchronous active-high reset
//   req_valid/ready/addr   : refill request (any byte inside the line)
//   resp_valid/ready       : completed-line handshake
//   resp_data              : line, word k at [k*DATA_WIDTH +: DATA_WIDTH]
//   resp_err               : SLVERR/DECERR seen or rlast misplaced
//   mem_if                 : AXI4 master port (write channels tied off)
`timescale 1ns/1ps
module axi4_line_fetch #(
  parameter int DATA_WIDTH = 32,
  parameter int LINE_WORDS = 4,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic [ADDR_WIDTH-1:0]            req_addr,
  output logic                             resp_valid,
  input  logic                             resp_ready,
  output logic [LINE_WORDS*DATA_WIDTH-1:0] resp_data,
  output logic                             resp_err,
  axi4_if.master                           mem_if
);

  localparam int OFF_BITS  = $clog2(LINE_WORDS * DATA_WIDTH / 8);
  localparam int SIZE_LOG2 = $clog2(DATA_WIDTH / 8);
  // one extra bit so the counter can sit at LINE_WORDS while draining
  localparam int CNT_W     = $clog2(LINE_WORDS) + 1;

  localparam logic [ADDR_WIDTH-1:0] OFF_MASK  = ADDR_WIDTH'((64'd1 << OFF_BITS) - 64'd1);
  localparam logic [CNT_W-1:0]      CNT_FULL  = CNT_W'(LINE_WORDS);
  localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {IDLE, AR, R, DONE} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    err_q, err_d;
  logic                    wr_en;

  always_comb begin
    state_d  = state_q;
    araddr_d = araddr_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    wr_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d  = AR;
          araddr_d = req_addr & ~OFF_MASK;
          cnt_d    = '0;
          err_d    = 1'b0;
        end
      end
      AR: begin
        if (mem_if.arready) state_d = R;
      end
      R: begin
        if (mem_if.rvalid) begin
          // once the counter saturates, extra beats are consumed but dropped
          if (cnt_q != CNT_FULL) begin
            wr_en = 1'b1;
            cnt_d = cnt_q + CNT_W'(1);
          end
          if (mem_if.rresp != 2'b00) err_d = 1'b1;
          if (mem_if.rlast) begin
            state_d = DONE;
            if (cnt_q != CNT_LAST) err_d = 1'b1;   // rlast too early (or late)
          end else if (cnt_q == CNT_LAST) begin
            err_d = 1'b1;                          // rlast missing on final beat
          end
        end
      end
      DONE: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      araddr_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      araddr_q <= araddr_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  // line buffer: one register per word, written at the current beat index
  genvar gi;
  generate
    for (gi = 0; gi < LINE_WORDS; gi++) begin : g_word
      logic [DATA_WIDTH-1:0] word_q;
      always_ff @(posedge clk) begin
        if (reset) begin
          word_q <= '0;
        end else if (wr_en && (cnt_q == CNT_W'(gi))) begin
          word_q <= mem_if.rdata;
        end
      end
      assign resp_data[gi*DATA_WIDTH +: DATA_WIDTH] = word_q;
    end
  endgenerate

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == DONE);
  assign resp_err   = err_q;

  assign mem_if.arvalid = (state_q == AR);
  assign mem_if.araddr  = araddr_q;
  assign mem_if.arlen   = 8'(LINE_WORDS - 1);
  assign mem_if.arsize  = 3'(SIZE_LOG2);
  assign mem_if.arburst = 2'b01;
  assign mem_if.rready  = (state_q == R);

  assign mem_if.awvalid = 1'b0;
  assign mem_if.awaddr  = '0;
  assign mem_if.awlen   = '0;
  assign mem_if.awsize  = '0;
  assign mem_if.awburst = '0;
  assign mem_if.wvalid  = 1'b0;
  assign mem_if.wdata   = '0;
  assign mem_if.wstrb   = '0;
  assign mem_if.wlast   = 1'b0;
  assign mem_if.bready  = 1'b0;

  // write-channel responses are never used by a read-only master
  logic unused_wr_inputs;
  assign unused_wr_inputs = ^{mem_if.awready, mem_if.wready, mem_if.bvalid, mem_if.bresp};

endmodule

// File: tb/tb_axi4_line_fetch.sv
`timescale 1ns/1ps
module tb_axi4_line_fetch;
  localparam int DW = 32;
  localparam int LW = 4;
  localparam int AW = 32;

  logic           clk = 1'b0;
  logic           reset;
  logic           req_valid;
  logic           req_ready;
  logic [AW-1:0]  req_addr;
  logic           resp_valid;
  logic           resp_ready;
  logic [LW*DW-1:0] resp_data;
  logic           resp_err;

  axi4_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mem_if ();

  axi4_line_fetch #(.DATA_WIDTH(DW), .LINE_WORDS(LW), .ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .mem_if     (mem_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ar_hs  = 0;

  // slave memory image: word i lives at byte 0x8000_0000 + 4*i
  logic [31:0] rom      [0:63];
  logic [31:0] exp_line [0:LW-1];
  logic [1:0]  resp_pat [0:15];

  always @(posedge clk) begin
    if (mem_if.arvalid === 1'b1 && mem_if.arready === 1'b1) ar_hs++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] model_line();
    logic [127:0] v;
    v = '0;
    for (int k = 0; k < LW; k++) v[k*DW +: DW] = exp_line[k];
    return v;
  endfunction

  // One refill: nbeats = number of R beats the slave sends (rlast on the
  // final one), resp_pat supplies rresp per beat.
  task automatic txn(input logic [31:0] addr, input int ar_delay, input int gap_max,
                     input int nbeats, input int hold);
    logic [31:0] exp_araddr;
    logic [31:0] d;
    int          base_idx;
    int          hs0;
    int          gap;
    logic        exp_err;
    exp_araddr = addr & ~32'h0000_000F;
    base_idx   = int'((exp_araddr - 32'h8000_0000) >> 2) & 63;
    hs0        = ar_hs;
    exp_err    = (nbeats != LW);

    check("req_ready_idle", req_ready, 1'b1);
    req_valid = 1'b1;
    req_addr  = addr;
    step();
    req_valid = 1'b0;
    req_addr  = $urandom;
    check("req_ready_busy", req_ready, 1'b0);

    for (int i = 0; i <= ar_delay; i++) begin
      check("arvalid", mem_if.arvalid, 1'b1);
      check("araddr", mem_if.araddr, exp_araddr);
      check("arlen", mem_if.arlen, 8'd3);
      check("arsize", mem_if.arsize, 3'd2);
      check("arburst", mem_if.arburst, 2'd1);
      check("rready_in_ar", mem_if.rready, 1'b0);
      mem_if.arready = (i == ar_delay);
      step();
    end
    mem_if.arready = 1'b0;
    check("arvalid_after_hs", mem_if.arvalid, 1'b0);
    check("rready_after_hs", mem_if.rready, 1'b1);

    for (int b = 0; b < nbeats; b++) begin
      gap = $urandom_range(gap_max, 0);
      for (int g = 0; g < gap; g++) begin
        check("rready_gap", mem_if.rready, 1'b1);
        check("resp_valid_gap", resp_valid, 1'b0);
        step();
      end
      d = (b < LW) ? rom[(base_idx + b) & 63] : $urandom;
      if (b < LW) exp_line[b] = d;
      if (resp_pat[b] != 2'b00) exp_err = 1'b1;
      mem_if.rvalid = 1'b1;
      mem_if.rdata  = d;
      mem_if.rresp  = resp_pat[b];
      mem_if.rlast  = (b == nbeats - 1);
      step();
      mem_if.rvalid = 1'b0;
      mem_if.rlast  = 1'b0;
      mem_if.rresp  = 2'b00;
      if (b != nbeats - 1) check("resp_valid_midburst", resp_valid, 1'b0);
    end

    check("resp_valid", resp_valid, 1'b1);
    check("rready_done", mem_if.rready, 1'b0);
    check("resp_err", resp_err, exp_err);
    if (nbeats >= LW) check("resp_data", resp_data, model_line());
    for (int h = 0; h < hold; h++) begin
      step();
      check("resp_valid_hold", resp_valid, 1'b1);
      check("resp_err_hold", resp_err, exp_err);
      if (nbeats >= LW) check("resp_data_hold", resp_data, model_line());
    end
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    check("resp_valid_drop", resp_valid, 1'b0);
    check("req_ready_back", req_ready, 1'b1);
    check("ar_handshakes", ar_hs - hs0, 1);
    $display("txn addr=%h araddr=%h beats=%0d ar_wait=%0d hold=%0d err=%0b",
             addr, exp_araddr, nbeats, ar_delay, hold, exp_err);
  endtask

  initial begin
    logic [31:0] a;
    rom[0] = 32'h0000_0413;
    rom[1] = 32'h0010_0093;
    rom[2] = 32'h0020_0113;
    rom[3] = 32'h0030_0193;
    for (int i = 4; i < 64; i++) rom[i] = $urandom;
    for (int i = 0; i < 16; i++) resp_pat[i] = 2'b00;
    for (int k = 0; k < LW; k++) exp_line[k] = '0;

    reset          = 1'b1;
    req_valid      = 1'b0;
    req_addr       = '0;
    resp_ready     = 1'b0;
    mem_if.arready = 1'b0;
    mem_if.rvalid  = 1'b0;
    mem_if.rdata   = '0;
    mem_if.rresp   = 2'b00;
    mem_if.rlast   = 1'b0;
    mem_if.awready = 1'b0;
    mem_if.wready  = 1'b0;
    mem_if.bvalid  = 1'b0;
    mem_if.bresp   = 2'b00;

    step();
    step();
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_arvalid", mem_if.arvalid, 1'b0);
    check("rst_rready", mem_if.rready, 1'b0);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_resp_err", resp_err, 1'b0);
    check("rst_resp_data", resp_data, 128'd0);
    check("rst_awvalid", mem_if.awvalid, 1'b0);
    check("rst_wvalid", mem_if.wvalid, 1'b0);
    reset = 1'b0;
    step();

    // basic zero-wait refill of the known instruction words
    txn(32'h8000_0000, 0, 0, 4, 0);
    check("basic_line", resp_data, 128'h00300193_00200113_00100093_00000413);

    // unaligned request rounds down to 0x8000_0010
    txn(32'h8000_001C, 0, 0, 4, 0);

    // slave and consumer backpressure
    txn(32'h8000_0040, 3, 2, 4, 5);

    // SLVERR on beat 2, then a clean refill clears the flag
    resp_pat[2] = 2'b10;
    txn(32'h8000_0050, 0, 1, 4, 0);
    resp_pat[2] = 2'b00;
    txn(32'h8000_0060, 1, 0, 4, 1);

    // rlast on beat 1, then six beats with rlast only on the last
    txn(32'h8000_0070, 0, 0, 2, 0);
    txn(32'h8000_0080, 0, 1, 6, 0);

    // randomized refills
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < LW; i++)
        resp_pat[i] = ($urandom_range(3, 0) == 0) ? 2'($urandom_range(3, 1)) : 2'b00;
      a = 32'h8000_0000 + (32'($urandom_range(15, 0)) << 4) + 32'($urandom_range(15, 0));
      txn(a, $urandom_range(3, 0), $urandom_range(2, 0), 4, $urandom_range(3, 0));
    end
    for (int i = 0; i < 16; i++) resp_pat[i] = 2'b00;

    // reset after beat 1 of a burst
    req_valid = 1'b1;
    req_addr  = 32'h8000_0020;
    step();
    req_valid      = 1'b0;
    mem_if.arready = 1'b1;
    step();
    mem_if.arready = 1'b0;
    for (int b = 0; b < 2; b++) begin
      mem_if.rvalid = 1'b1;
      mem_if.rdata  = rom[8 + b];
      mem_if.rlast  = 1'b0;
      step();
    end
    mem_if.rvalid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midrst_rready", mem_if.rready, 1'b0);
    check("midrst_req_ready", req_ready, 1'b1);
    check("midrst_arvalid", mem_if.arvalid, 1'b0);
    check("midrst_resp_valid", resp_valid, 1'b0);
    check("midrst_resp_data", resp_data, 128'd0);
    for (int k = 0; k < LW; k++) exp_line[k] = '0;
    txn(32'h8000_0000, 0, 0, 4, 0);
    check("post_rst_line", resp_data, 128'h00300193_00200113_00100093_00000413);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
